// File: rtl/seq_det_ctrl_pkg.sv
// Shared types and helpers for the programmable serial-pattern detector.
// Build option: define SEQ_DET_OVERLAP_EN to allow overlapping matches.
package seq_det_ctrl_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_e;

  // A pattern length is usable only if it selects at least one bit and fits the history.
  function automatic logic len_legal(input int unsigned len, input int unsigned pat_w);
    return (len != 0) && (len <= pat_w);
  endfunction

endpackage

// File: rtl/seq_det_match.sv
// History shift register, fill counter and masked pattern compare.
// Build option: SEQ_DET_OVERLAP_EN keeps fill after a match (overlapping detection).
module seq_det_match
  import seq_det_ctrl_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             sample_i,
  input  logic             n_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             match_o
);

  logic [PAT_W-1:0] hist_q, hist_d, mask;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [LEN_W:0]   fill_inc;

  always_comb begin
    for (int i = 0; i < PAT_W; i++) mask[i] = (i < int'(len_i));
  end

  assign hist_d   = {hist_q[PAT_W-2:0], n_i};
  assign fill_inc = {1'b0, fill_q} + (LEN_W+1)'(1);
  // Compare against the history as it will be after this bit shifts in.
  assign match_o  = sample_i && (fill_inc >= {1'b0, len_i}) &&
                    ((hist_d & mask) == (pattern_i & mask));

  always_comb begin
    fill_d = fill_q;
    if (clear_i) begin
      fill_d = '0;
    end else if (sample_i) begin
`ifdef SEQ_DET_OVERLAP_EN
      if (fill_q < LEN_W'(PAT_W)) fill_d = fill_inc[LEN_W-1:0];
`else
      if (match_o) fill_d = '0;
      else if (fill_q < LEN_W'(PAT_W)) fill_d = fill_inc[LEN_W-1:0];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      if (clear_i) hist_q <= '0;
      else if (sample_i) hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Programmable serial-pattern detection controller: arm/disarm FSM, match counter, pending/ack.
// Build option: SEQ_DET_OVERLAP_EN (handled in seq_det_match) enables overlapping matches.
module seq_det_ctrl
  import seq_det_ctrl_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             arm,
  input  logic             disarm,
  input  logic             n,
  input  logic             n_valid,
  input  logic             hit_ack,
  output logic             op,
  output logic             hit_pending,
  output logic             overrun,
  output logic             cfg_err,
  output logic             armed,
  output logic [CNT_W-1:0] match_cnt
);

  // Handshake: hit_pending rises on a match and holds until a cycle with hit_ack high and
  // no new match; a match while pending without hit_ack in the same cycle sets overrun.

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0] len_q, len_d, eff_len;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d, pend_q, pend_d, over_q, over_d, err_q, err_d;
  logic             clear, sample, match;

  seq_det_match #(.PAT_W(PAT_W), .LEN_W(LEN_W)) u_match (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (clear),
    .sample_i  (sample),
    .n_i       (n),
    .pattern_i (pattern_q),
    .len_i     (len_q),
    .match_o   (match)
  );

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    over_d    = over_q;
    op_d      = 1'b0;
    err_d     = 1'b0;
    clear     = 1'b0;
    sample    = 1'b0;
    // An arm in the same cycle as cfg_we is checked against the incoming length.
    eff_len   = (state_q == ST_IDLE && cfg_we) ? cfg_len : len_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_we) begin
          pattern_d = cfg_pattern;
          len_d     = cfg_len;
        end
        if (arm && !disarm) begin
          if (len_legal(32'(eff_len), 32'(PAT_W))) begin
            state_d = ST_ARMED;
            clear   = 1'b1;
            cnt_d   = '0;
            over_d  = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_ARMED: begin
        if (cfg_we) err_d = 1'b1;
        if (disarm) state_d = ST_IDLE;
        else sample = n_valid;
      end
      default: state_d = ST_IDLE;
    endcase
    if (hit_ack) pend_d = 1'b0;
    if (match) begin
      op_d   = 1'b1;
      pend_d = 1'b1;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
      if (pend_q && !hit_ack) over_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pattern_q <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      op_q      <= 1'b0;
      pend_q    <= 1'b0;
      over_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      pend_q    <= pend_d;
      over_q    <= over_d;
      err_q     <= err_d;
    end
  end

  assign op          = op_q;
  assign hit_pending = pend_q;
  assign overrun     = over_q;
  assign cfg_err     = err_q;
  assign armed       = (state_q == ST_ARMED);
  assign match_cnt   = cnt_q;

endmodule
